icache_l2_line_responder: RTL and testbench



---
 rtl/l2_resp_pkg.sv | 21 ++
 rtl/icache_l2_line_responder.sv | 117 +++++++++++
 tb/tb_icache_l2_line_responder.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_resp_pkg.sv
// Shared types and line-geometry helpers for the L2 line responder and the Icache side.
package l2_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  localparam int BURST_LEN_W = 8;

  function automatic int calc_offset_width(input int data_w, input int blk_size);
    return $clog2(data_w * blk_size / 8);
  endfunction

  function automatic int calc_cache_width(input int data_w, input int blk_size);
    return data_w * blk_size;
  endfunction

endpackage

// File: rtl/icache_l2_line_responder.sv
// Icache line-fill responder: issues one read burst per line request, assembles
// the beats into a line buffer and returns the whole line on a one-cycle pulse.
module icache_l2_line_responder
  import l2_resp_pkg::*;
#(
  parameter int data_width    = 32,
  parameter int address_width = 32,
  parameter int block_size    = 32,
  localparam int offset_width = calc_offset_width(data_width, block_size),
  localparam int cache_width  = calc_cache_width(data_width, block_size)
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  ADDR_FROM_L1_VALID,
  input  logic [address_width-offset_width-1:0] ADDR_FROM_L1,
  output logic [cache_width-1:0]                DATA_TO_L1,
  output logic                                  DATA_TO_L1_VALID,
  output logic                                  BUSY,
  output logic                                  MEM_ARVALID,
  input  logic                                  MEM_ARREADY,
  output logic [address_width-1:0]              MEM_ARADDR,
  output logic [BURST_LEN_W-1:0]                MEM_ARLEN,
  input  logic                                  MEM_RVALID,
  output logic                                  MEM_RREADY,
  input  logic [data_width-1:0]                 MEM_RDATA,
  input  logic                                  MEM_RLAST,
  output logic                                  ERR
);

  localparam int BEAT_W = (block_size > 1) ? $clog2(block_size) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(block_size - 1);

  state_t                                state;
  state_t                                next_state;
  logic [address_width-offset_width-1:0] line_addr;
  logic [BEAT_W-1:0]                     beat;
  logic [data_width-1:0]                 line_buf [block_size];
  logic                                  err;
  logic                                  beat_fire;
  logic                                  last_beat;

  assign beat_fire = MEM_RVALID & MEM_RREADY;
  assign last_beat = (beat == LAST_BEAT);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Completion is counted locally; MEM_RLAST only feeds the error flag.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (ADDR_FROM_L1_VALID) next_state = ADDR;
      ADDR:    if (MEM_ARREADY) next_state = DATA;
      DATA:    if (beat_fire && last_beat) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    MEM_ARVALID      = 1'b0;
    MEM_RREADY       = 1'b0;
    DATA_TO_L1_VALID = 1'b0;
    BUSY             = (state != IDLE);
    unique case (state)
      ADDR:    MEM_ARVALID = 1'b1;
      DATA:    MEM_RREADY = 1'b1;
      RESP:    DATA_TO_L1_VALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      line_addr <= '0;
      beat      <= '0;
      err       <= 1'b0;
    end else begin
      if (state == IDLE && ADDR_FROM_L1_VALID) begin
        line_addr <= ADDR_FROM_L1;
      end
      if (state == ADDR && MEM_ARREADY) begin
        beat <= '0;
      end else if (beat_fire) begin
        beat <= beat + 1'b1;
      end
      if (beat_fire && (MEM_RLAST != last_beat)) begin
        err <= 1'b1;
      end
    end
  end

  // Beat k lands in word k, matching the Icache word select on addr[offset-1:2].
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < block_size; i++) begin
        line_buf[i] <= '0;
      end
    end else if (beat_fire) begin
      line_buf[beat] <= MEM_RDATA;
    end
  end

  for (genvar g = 0; g < block_size; g++) begin : g_line_out
    assign DATA_TO_L1[g*data_width +: data_width] = line_buf[g];
  end

  assign MEM_ARADDR = {line_addr, {offset_width{1'b0}}};
  assign MEM_ARLEN  = BURST_LEN_W'(block_size - 1);
  assign ERR        = err;

endmodule

// File: tb/tb_icache_l2_line_responder.sv
// Scoreboard bench for icache_l2_line_responder with a reactive burst memory model.
module tb_icache_l2_line_responder;
  import l2_resp_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 32;
  localparam int OW = calc_offset_width(DW, BS);
  localparam int CW = calc_cache_width(DW, BS);

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              ADDR_FROM_L1_VALID = 1'b0;
  logic [AW-OW-1:0]  ADDR_FROM_L1 = '0;
  logic [CW-1:0]     DATA_TO_L1;
  logic              DATA_TO_L1_VALID;
  logic              BUSY;
  logic              MEM_ARVALID;
  logic              MEM_ARREADY;
  logic [AW-1:0]     MEM_ARADDR;
  logic [7:0]        MEM_ARLEN;
  logic              MEM_RVALID;
  logic              MEM_RREADY;
  logic [DW-1:0]     MEM_RDATA;
  logic              MEM_RLAST;
  logic              ERR;

  typedef struct {
    logic [CW-1:0] line;
    int            req_cyc;
    int            latency;
    logic          err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ar_delay = 0;
  int          rvalid_gap = 0;
  int          rlast_beat = BS - 1;
  logic [31:0] data_base = 32'h0;
  int          ar_wait = 0;
  logic        in_burst = 1'b0;
  int          beats_taken = 0;
  int          burst_cyc = 0;
  int          busy_req_cnt = 0;

  icache_l2_line_responder #(
    .data_width   (DW),
    .address_width(AW),
    .block_size   (BS)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .ADDR_FROM_L1_VALID(ADDR_FROM_L1_VALID),
    .ADDR_FROM_L1      (ADDR_FROM_L1),
    .DATA_TO_L1        (DATA_TO_L1),
    .DATA_TO_L1_VALID  (DATA_TO_L1_VALID),
    .BUSY              (BUSY),
    .MEM_ARVALID       (MEM_ARVALID),
    .MEM_ARREADY       (MEM_ARREADY),
    .MEM_ARADDR        (MEM_ARADDR),
    .MEM_ARLEN         (MEM_ARLEN),
    .MEM_RVALID        (MEM_RVALID),
    .MEM_RREADY        (MEM_RREADY),
    .MEM_RDATA         (MEM_RDATA),
    .MEM_RLAST         (MEM_RLAST),
    .ERR               (ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (!RST && ADDR_FROM_L1_VALID && BUSY) busy_req_cnt <= busy_req_cnt + 1;
  end

  // Memory side bookkeeping; it shares the DUT reset.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_burst    <= 1'b0;
      beats_taken <= 0;
      burst_cyc   <= 0;
    end else if (MEM_ARVALID && MEM_ARREADY) begin
      in_burst    <= 1'b1;
      beats_taken <= 0;
      burst_cyc   <= 0;
    end else if (in_burst) begin
      burst_cyc <= burst_cyc + 1;
      if (MEM_RVALID && MEM_RREADY) begin
        beats_taken <= beats_taken + 1;
        if (beats_taken == BS - 1) in_burst <= 1'b0;
      end
    end
  end

  initial begin
    MEM_ARREADY = 1'b0;
    MEM_RVALID  = 1'b0;
    MEM_RDATA   = '0;
    MEM_RLAST   = 1'b0;
    forever begin
      @(negedge CLK);
      if (MEM_ARVALID) begin
        if (ar_wait >= ar_delay) MEM_ARREADY = 1'b1;
        else begin
          MEM_ARREADY = 1'b0;
          ar_wait++;
        end
      end else begin
        MEM_ARREADY = 1'b0;
        ar_wait = 0;
      end
      if (in_burst && beats_taken < BS && (rvalid_gap == 0 || burst_cyc % 2 == 0)) begin
        MEM_RVALID = 1'b1;
        MEM_RDATA  = data_base + beats_taken;
        MEM_RLAST  = (beats_taken == rlast_beat);
      end else begin
        MEM_RVALID = 1'b0;
        MEM_RDATA  = 32'hDEAD_BEEF;
        MEM_RLAST  = 1'b0;
      end
    end
  end

  function automatic logic [CW-1:0] make_line(input logic [31:0] base);
    logic [CW-1:0] l;
    for (int k = 0; k < BS; k++) l[k*DW +: DW] = DW'(base + k);
    return l;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < BS; k++) begin
        if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $display("[TB] FAIL %s: word %0d got 0x%0h, expected 0x%0h",
                   name, k, act[k*DW +: DW], exp[k*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Scoreboard monitor: every line return pops and checks one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DATA_TO_L1_VALID) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check_line("line", DATA_TO_L1, e.line);
          check_output("latency", 64'(cyc - e.req_cyc), 64'(e.latency));
          check_output("err_at_pulse", 64'(ERR), 64'(e.err));
          check_output("beats_consumed", 64'(beats_taken), 64'(BS));
          check_output("rready_in_resp", 64'(MEM_RREADY), 64'd0);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [AW-OW-1:0] line_addr, input logic [31:0] exp_araddr,
                                input logic [31:0] base, input int latency, input logic exp_err);
    exp_t e;
    @(negedge CLK);
    ADDR_FROM_L1       = line_addr;
    ADDR_FROM_L1_VALID = 1'b1;
    data_base          = base;
    e.line    = make_line(base);
    e.req_cyc = cyc;
    e.latency = latency;
    e.err     = exp_err;
    sb.push_back(e);
    @(negedge CLK);
    ADDR_FROM_L1_VALID = 1'b0;
    check_output("arvalid", 64'(MEM_ARVALID), 64'd1);
    check_output("araddr", 64'(MEM_ARADDR), 64'(exp_araddr));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL pulse_timeout: got %0d pending lines, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_pulse();
    int n = 0;
    while (!DATA_TO_L1_VALID && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!DATA_TO_L1_VALID) begin
      checks++;
      errors++;
      $display("[TB] FAIL pulse_wait_timeout: got no pulse, expected one");
    end
  endtask

  task automatic wait_beats(input int n_beats);
    int n = 0;
    while (beats_taken != n_beats && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (beats_taken != n_beats) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_wait_timeout: got %0d beats, expected %0d", beats_taken, n_beats);
    end
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_output("rst_busy", 64'(BUSY), 64'd0);
    check_output("rst_arvalid", 64'(MEM_ARVALID), 64'd0);
    check_output("rst_rready", 64'(MEM_RREADY), 64'd0);
    check_output("rst_valid", 64'(DATA_TO_L1_VALID), 64'd0);
    check_output("rst_err", 64'(ERR), 64'd0);
    check_output("rst_araddr", 64'(MEM_ARADDR), 64'd0);
    check_output("arlen", 64'(MEM_ARLEN), 64'd31);
    check_line("rst_line", DATA_TO_L1, '0);
    RST = 1'b0;

    // Single fill, memory always ready.
    apply_stimulus(25'h20, 32'h0000_1000, 32'h1000, 34, 1'b0);
    wait_idle();

    // Delayed address accept and gapped beats.
    ar_delay   = 3;
    rvalid_gap = 1;
    apply_stimulus(25'h20, 32'h0000_1000, 32'h1000, 68, 1'b0);
    wait_idle();
    ar_delay   = 0;
    rvalid_gap = 0;

    // Back-to-back: second request the cycle after the return pulse.
    apply_stimulus(25'h21, 32'h0000_1080, 32'h2000, 34, 1'b0);
    wait_pulse();
    apply_stimulus(25'h40, 32'h0000_2000, 32'h2100, 34, 1'b0);
    check_line("line_held", DATA_TO_L1, make_line(32'h2000));
    wait_idle();

    // Request injected while a burst is in flight must be ignored.
    apply_stimulus(25'h22, 32'h0000_1100, 32'h3000, 34, 1'b0);
    wait_beats(5);
    ADDR_FROM_L1       = 25'h1ABCDE;
    ADDR_FROM_L1_VALID = 1'b1;
    @(negedge CLK);
    ADDR_FROM_L1_VALID = 1'b0;
    check_output("araddr_kept", 64'(MEM_ARADDR), 64'h1100);
    wait_idle();
    repeat (3) @(negedge CLK);
    check_output("idle_after_busy_req", 64'(BUSY), 64'd0);
    check_output("busy_req_seen", 64'(busy_req_cnt), 64'd1);

    // RLAST early on beat 15.
    rlast_beat = 15;
    apply_stimulus(25'h23, 32'h0000_1180, 32'h4000, 34, 1'b1);
    wait_beats(15);
    check_output("err_before_rlast", 64'(ERR), 64'd0);
    wait_beats(16);
    check_output("err_after_rlast", 64'(ERR), 64'd1);
    wait_idle();
    rlast_beat = BS - 1;
    check_output("err_sticky", 64'(ERR), 64'd1);

    // Asynchronous reset after beat 10.
    apply_stimulus(25'h30, 32'h0000_1800, 32'h5000, 34, 1'b0);
    wait_beats(11);
    #1 RST = 1'b1;
    #1;
    check_output("mid_rst_busy", 64'(BUSY), 64'd0);
    check_output("mid_rst_rready", 64'(MEM_RREADY), 64'd0);
    check_output("mid_rst_arvalid", 64'(MEM_ARVALID), 64'd0);
    check_output("mid_rst_valid", 64'(DATA_TO_L1_VALID), 64'd0);
    check_output("mid_rst_err", 64'(ERR), 64'd0);
    check_output("mid_rst_araddr", 64'(MEM_ARADDR), 64'd0);
    check_line("mid_rst_line", DATA_TO_L1, '0);
    sb.delete();
    #1 RST = 1'b0;
    repeat (40) @(negedge CLK);

    apply_stimulus(25'h31, 32'h0000_1880, 32'h6000, 34, 1'b0);
    wait_idle();
    repeat (2) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
